// File: rtl/firebird7_in_gate1_mbist_diag_arbiter.sv
// firebird7 gate1 MBIST diagnosis arbiter: round-robin grant of the shared
// readout path among NUM_CTL controllers, steered and released through an IJTAG TDR.
// Optional grant watchdog: define FIREBIRD7_IN_DIAG_ARB_TIMEOUT_EN.
module firebird7_in_gate1_mbist_diag_arbiter #(
   parameter int NUM_CTL     = 4,
   parameter int IDX_W       = $clog2(NUM_CTL),
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               ijtag_tck,
   input  logic               ijtag_reset,
   input  logic               ijtag_sel,
   input  logic               ijtag_si,
   input  logic               ijtag_ce,
   input  logic               ijtag_se,
   input  logic               ijtag_ue,
   output logic               ijtag_so,
   input  logic [NUM_CTL-1:0] diag_req,
   output logic [NUM_CTL-1:0] diag_grant,
   output logic               diag_active
);

   localparam int TDR_W = NUM_CTL + IDX_W + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      REL   = 2'd2
   } state_t;

   state_t             state;
   logic [TDR_W-1:0]   shift_q;
   logic [NUM_CTL:0]   upd_q;
   logic               release_tgl;
   logic               release_seen;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   last_idx;
   logic               timeout_flag;
   logic               expire;

   logic               arb_en;
   logic [NUM_CTL-1:0] req_mask;
   logic [NUM_CTL-1:0] eligible;
   logic               capture;
   logic               shift_en;
   logic               update;
   logic [TDR_W-1:0]   cap_word;
   logic               rel_req;
   logic               abort;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;
   logic [IDX_W-1:0]   cand_idx;
   int                 cand;

   assign arb_en   = upd_q[0];
   assign req_mask = upd_q[NUM_CTL:1];
   assign eligible = diag_req & ~req_mask & {NUM_CTL{arb_en}};
   assign capture  = ijtag_ce & ijtag_sel;
   assign shift_en = ijtag_se & ijtag_sel;
   assign update   = ijtag_ue & ijtag_sel;
   assign cap_word = {timeout_flag, diag_req, grant_idx, diag_active};
   assign rel_req  = release_tgl != release_seen;
   assign abort    = ~diag_req[grant_idx];

   // Round robin: nearest eligible index after last_idx, wrapping past NUM_CTL-1.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = last_idx;
      cand     = 0;
      cand_idx = '0;
      for (int k = NUM_CTL; k >= 1; k--) begin
         cand = int'(last_idx) + k;
         if (cand >= NUM_CTL) cand = cand - NUM_CTL;
         cand_idx = IDX_W'(cand);
         if (eligible[cand_idx]) begin
            pick_vld = 1'b1;
            pick_idx = cand_idx;
         end
      end
   end

   // TDR shift register: capture status or shift toward ijtag_so.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         shift_q <= '0;
      end else if (capture) begin
         shift_q <= cap_word;
      end else if (shift_en) begin
         shift_q <= {ijtag_si, shift_q[TDR_W-1:1]};
      end
   end

   // Falling-edge side: control update, release toggle, retimed scan out.
   always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         upd_q       <= '0;
         release_tgl <= 1'b0;
         ijtag_so    <= 1'b0;
      end else begin
         ijtag_so <= shift_q[0];
         if (update) begin
            upd_q <= shift_q[NUM_CTL+1:1];
            if (shift_q[0]) release_tgl <= ~release_tgl;
         end
      end
   end

   // Arbitration FSM with registered grant outputs.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         state        <= IDLE;
         grant_idx    <= '0;
         last_idx     <= IDX_W'(NUM_CTL - 1);
         release_seen <= 1'b0;
         diag_grant   <= '0;
         diag_active  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  state        <= GRANT;
                  grant_idx    <= pick_idx;
                  release_seen <= release_tgl;
                  diag_grant   <= NUM_CTL'(1) << pick_idx;
                  diag_active  <= 1'b1;
               end
            end
            GRANT: begin
               if (rel_req || abort || expire) begin
                  state       <= REL;
                  diag_grant  <= '0;
                  diag_active <= 1'b0;
               end
            end
            REL: begin
               last_idx <= grant_idx;
               state    <= IDLE;
            end
            default: begin
               state       <= IDLE;
               diag_grant  <= '0;
               diag_active <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIREBIRD7_IN_DIAG_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wd_cnt;

   assign expire = (state == GRANT) && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Grant watchdog and sticky timeout flag (cleared by capture with arb_en low).
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         wd_cnt       <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (state != GRANT) wd_cnt <= '0;
         else if (!expire)   wd_cnt <= wd_cnt + 1'b1;
         if (expire)                  timeout_flag <= 1'b1;
         else if (capture && !arb_en) timeout_flag <= 1'b0;
      end
   end
`else
   assign expire       = 1'b0;
   assign timeout_flag = 1'b0;
`endif

endmodule
